dm_port_arbiter: RTL and testbench

- Sits between the two CPU cores' data-memory ports (p0, p1) and the shared true dual-port data RAM.
- Detects same-address collisions and arbitrates write-write collisions with a round-robin priority. The losing core is stalled and retries.
- On a same-address read-during-write it forwards the write data to the reader, so RAM read-during-write behaviour never shows at the cores.
- Replaces the fixed p1-wins, p0-write-dropped conflict gating in the top level.

---
 rtl/dm_arb_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 35 +++
 rtl/dm_port_arbiter.sv | 105 ++++++++++
 tb/tb_dm_port_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared defaults and types for the dual-core data-memory port arbiter.
// Priority state and per-port request bundle live here so the arbiter and its users agree.
package dm_arb_pkg;

  localparam int DM_DATA_W = 16;
  localparam int DM_ADDR_W = 9;
  localparam int DM_RAM_AW = 8;

  typedef enum logic {
    PRI_P0 = 1'b0,
    PRI_P1 = 1'b1
  } pri_e;

  typedef struct packed {
    logic                 req;
    logic                 we;
    logic [DM_ADDR_W-1:0] addr;
    logic [DM_DATA_W-1:0] wdata;
  } port_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant: grants pass through unless both collide,
// in which case only the priority holder wins and priority moves to the loser.
module rr_arb2
  import dm_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       collide,
  output logic [1:0] gnt
);

  pri_e pri_q, pri_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) pri_q <= PRI_P0;
    else     pri_q <= pri_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    pri_d = pri_q;
    gnt   = req;
    if (rst) begin
      gnt = 2'b00;
    end else if (collide) begin
      gnt   = (pri_q == PRI_P0) ? 2'b01 : 2'b10;
      pri_d = (pri_q == PRI_P0) ? PRI_P1 : PRI_P0;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Arbitrates two core data-memory ports onto a true dual-port RAM with write-write
// round-robin stalls and read-during-write forwarding. Optional DM_ARB_STATS_EN adds coll_cnt.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int DATA_W = DM_DATA_W,
  parameter int ADDR_W = DM_ADDR_W,
  parameter int RAM_AW = DM_RAM_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_rvalid,
  output logic [RAM_AW-1:0] ram_addr_a,
  output logic              ram_we_a,
  output logic [DATA_W-1:0] ram_data_a,
  input  logic [DATA_W-1:0] ram_q_a,
  output logic [RAM_AW-1:0] ram_addr_b,
  output logic              ram_we_b,
  output logic [DATA_W-1:0] ram_data_b,
  input  logic [DATA_W-1:0] ram_q_b,
  output logic [15:0]       coll_cnt
);

  logic              collide, ww_collide;
  logic [1:0]        gnt;
  logic              rvalid0_q, rvalid1_q, fwd0_q, fwd1_q;
  logic [DATA_W-1:0] wd0_q, wd1_q;

  // Upper address bits alias onto the same RAM word and are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{p0_addr[ADDR_W-1:RAM_AW], p1_addr[ADDR_W-1:RAM_AW]};

  assign ram_addr_a = p0_addr[RAM_AW-1:0];
  assign ram_addr_b = p1_addr[RAM_AW-1:0];
  assign ram_data_a = p0_wdata;
  assign ram_data_b = p1_wdata;

  assign collide    = p0_req & p1_req & (ram_addr_a == ram_addr_b);
  assign ww_collide = collide & p0_we & p1_we;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req     ({p1_req, p0_req}),
    .collide (ww_collide),
    .gnt     (gnt)
  );

  assign p0_gnt   = gnt[0];
  assign p1_gnt   = gnt[1];
  assign ram_we_a = p0_gnt & p0_we;
  assign ram_we_b = p1_gnt & p1_we;

  // A reader colliding with a writer gets the in-flight write data instead of
  // whatever the RAM returns for its read-during-write case.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      fwd0_q    <= 1'b0;
      fwd1_q    <= 1'b0;
      wd0_q     <= '0;
      wd1_q     <= '0;
    end else begin
      rvalid0_q <= p0_gnt & ~p0_we;
      rvalid1_q <= p1_gnt & ~p1_we;
      fwd0_q    <= collide & ~p0_we & p1_we;
      fwd1_q    <= collide & ~p1_we & p0_we;
      wd0_q     <= p1_wdata;
      wd1_q     <= p0_wdata;
    end
  end

  assign p0_rvalid = rvalid0_q;
  assign p1_rvalid = rvalid1_q;
  assign p0_rdata  = fwd0_q ? wd0_q : ram_q_a;
  assign p1_rdata  = fwd1_q ? wd1_q : ram_q_b;

`ifdef DM_ARB_STATS_EN
  logic [15:0] coll_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                                     coll_cnt_q <= '0;
    else if (ww_collide && coll_cnt_q != 16'hFFFF) coll_cnt_q <= coll_cnt_q + 16'd1;
  end

  assign coll_cnt = coll_cnt_q;
`else
  assign coll_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Randomized self-checking bench for dm_port_arbiter against a word-level memory model.
// Honours DM_ARB_STATS_EN for the expected collision count.
module tb_dm_port_arbiter;
  import dm_arb_pkg::*;

  localparam int DW = DM_DATA_W;

  logic clk = 1'b0;
  logic rst;
  port_req_t in0, in1;

  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [7:0]    ram_addr_a, ram_addr_b;
  logic          ram_we_a, ram_we_b;
  logic [DW-1:0] ram_data_a, ram_data_b, ram_q_a, ram_q_b;
  logic [15:0]   coll_cnt;

  always #5 clk = ~clk;

  dm_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .p0_req     (in0.req),
    .p0_we      (in0.we),
    .p0_addr    (in0.addr),
    .p0_wdata   (in0.wdata),
    .p0_gnt     (p0_gnt),
    .p0_rdata   (p0_rdata),
    .p0_rvalid  (p0_rvalid),
    .p1_req     (in1.req),
    .p1_we      (in1.we),
    .p1_addr    (in1.addr),
    .p1_wdata   (in1.wdata),
    .p1_gnt     (p1_gnt),
    .p1_rdata   (p1_rdata),
    .p1_rvalid  (p1_rvalid),
    .ram_addr_a (ram_addr_a),
    .ram_we_a   (ram_we_a),
    .ram_data_a (ram_data_a),
    .ram_q_a    (ram_q_a),
    .ram_addr_b (ram_addr_b),
    .ram_we_b   (ram_we_b),
    .ram_data_b (ram_data_b),
    .ram_q_b    (ram_q_b),
    .coll_cnt   (coll_cnt)
  );

  // Read-first dual-port RAM: a same-address read during a write returns stale data,
  // so only arbiter forwarding can deliver the new value.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (ram_we_a) ram[ram_addr_a] <= ram_data_a;
    if (ram_we_b) ram[ram_addr_b] <= ram_data_b;
    ram_q_a <= ram[ram_addr_a];
    ram_q_b <= ram[ram_addr_b];
  end

  // Reference model state
  logic [DW-1:0] gold [256];
  int            fav;
  int            exp_cnt;
  bit            pend [2];
  logic [DW-1:0] exp_rd [2];
  bit            stalled [2];
  int            n_cmp, n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [8:0] a0, input logic [15:0] d0,
                       input logic r1, input logic w1, input logic [8:0] a1, input logic [15:0] d1);
    in0 = '{req: r0, we: w0, addr: a0, wdata: d0};
    in1 = '{req: r1, we: w1, addr: a1, wdata: d1};
  endtask

  // One clock of the model: inputs are already driven just after a negedge.
  task automatic cycle();
    bit [1:0]      eg;
    int            i0, i1;
    bit            col, ww;
    bit            np [2];
    logic [DW-1:0] nr [2];
    logic [15:0]   cnt_exp;
    #1;
    i0  = int'(in0.addr) % 256;
    i1  = int'(in1.addr) % 256;
    col = in0.req && in1.req && (i0 == i1);
    ww  = col && in0.we && in1.we;
    if (rst)     eg = 2'b00;
    else if (ww) eg = (fav == 0) ? 2'b01 : 2'b10;
    else         eg = {in1.req, in0.req};

    if (!rst && stalled[0] && in0.req) check("stall_bound_p0", p0_gnt, 1'b1);
    if (!rst && stalled[1] && in1.req) check("stall_bound_p1", p1_gnt, 1'b1);
    check("p0_gnt", p0_gnt, eg[0]);
    check("p1_gnt", p1_gnt, eg[1]);
    check("ram_we_a", ram_we_a, eg[0] && in0.we);
    check("ram_we_b", ram_we_b, eg[1] && in1.we);
    check("ram_addr_a", ram_addr_a, i0);
    check("ram_addr_b", ram_addr_b, i1);
    if (eg[0] && in0.we) check("ram_data_a", ram_data_a, in0.wdata);
    if (eg[1] && in1.we) check("ram_data_b", ram_data_b, in1.wdata);

    np[0] = eg[0] && !in0.we;
    np[1] = eg[1] && !in1.we;
    nr[0] = (eg[1] && in1.we && i1 == i0) ? in1.wdata : gold[i0];
    nr[1] = (eg[0] && in0.we && i0 == i1) ? in0.wdata : gold[i1];

    @(posedge clk);
    if (rst) begin
      fav     = 0;
      exp_cnt = 0;
    end else begin
      if (eg[0] && in0.we) gold[i0] = in0.wdata;
      if (eg[1] && in1.we) gold[i1] = in1.wdata;
      if (ww) begin
        fav = 1 - fav;
        if (exp_cnt < 65535) exp_cnt++;
      end
    end
    stalled[0] = !rst && in0.req && !eg[0];
    stalled[1] = !rst && in1.req && !eg[1];
    pend[0] = np[0];  pend[1] = np[1];
    exp_rd[0] = nr[0]; exp_rd[1] = nr[1];

    @(negedge clk);
    check("p0_rvalid", p0_rvalid, pend[0]);
    check("p1_rvalid", p1_rvalid, pend[1]);
    if (pend[0]) check("p0_rdata", p0_rdata, exp_rd[0]);
    if (pend[1]) check("p1_rdata", p1_rdata, exp_rd[1]);
`ifdef DM_ARB_STATS_EN
    cnt_exp = 16'(exp_cnt);
`else
    cnt_exp = 16'h0000;
`endif
    check("coll_cnt", coll_cnt, cnt_exp);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; fav = 0; exp_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      ram[i]  = '0;
      gold[i] = '0;
    end
    pend[0] = 0; pend[1] = 0; stalled[0] = 0; stalled[1] = 0;

    // Reset then idle
    rst = 1'b1;
    drive(0, 0, 9'h000, 16'h0, 0, 0, 9'h000, 16'h0);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // No collision: both write, then both read
    drive(1, 1, 9'h010, 16'h1234, 1, 1, 9'h020, 16'hABCD);
    cycle();
    drive(1, 0, 9'h010, 16'h0, 1, 0, 9'h020, 16'h0);
    cycle();
    check("rd_p0_1234", p0_rdata, 16'h1234);
    check("rd_p1_abcd", p1_rdata, 16'hABCD);
    drive(0, 0, 9'h000, 16'h0, 0, 0, 9'h000, 16'h0);
    cycle();

    // Three consecutive write-write collisions at 0x05
    drive(1, 1, 9'h005, 16'h1111, 1, 1, 9'h005, 16'h2222);
    cycle();
    cycle();
    cycle();
`ifdef DM_ARB_STATS_EN
    check("coll_cnt_3", coll_cnt, 16'd3);
`else
    check("coll_cnt_off", coll_cnt, 16'd0);
`endif

    // Read-during-write forwarding at 0x07
    drive(1, 0, 9'h007, 16'h0, 1, 1, 9'h007, 16'h5A5A);
    cycle();
    check("fwd_p0", p0_rdata, 16'h5A5A);
    drive(1, 0, 9'h007, 16'h0, 0, 0, 9'h000, 16'h0);
    cycle();
    check("ram_p0_after_fwd", p0_rdata, 16'h5A5A);

    // Address aliasing: 0x105 and 0x005 collide
    drive(1, 1, 9'h105, 16'hC0DE, 1, 1, 9'h005, 16'hBEEF);
    cycle();
    drive(0, 0, 9'h000, 16'h0, 0, 0, 9'h000, 16'h0);
    cycle();

    // Reset in the middle of a stall discards the stalled write
    drive(1, 1, 9'h030, 16'h7777, 1, 1, 9'h030, 16'h8888);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drive(0, 0, 9'h000, 16'h0, 0, 0, 9'h000, 16'h0);
    cycle();
    drive(1, 1, 9'h031, 16'h4444, 1, 1, 9'h031, 16'h5555);
    cycle();
    check("post_rst_pri_p0", p0_gnt, 1'b0);  // after the edge, inputs still held; p0 won last cycle
    drive(1, 0, 9'h030, 16'h0, 1, 0, 9'h031, 16'h0);
    cycle();

    // Randomized traffic on a small, aliased address set to force collisions
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      if (!stalled[0])
        drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              9'(($urandom_range(0, 1) << 8) | $urandom_range(0, 3)), 16'($urandom),
              in1.req, in1.we, in1.addr, in1.wdata);
      if (!stalled[1])
        drive(in0.req, in0.we, in0.addr, in0.wdata,
              ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              9'(($urandom_range(0, 1) << 8) | $urandom_range(0, 3)), 16'($urandom));
      cycle();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
